pe_cell_apb_sequencer: RTL and testbench
========================================

Name: pe_cell_apb_sequencer

Overview:
- Queued APB master that configures pe_cell_top. Software or test sequences push register read/write commands into a small command FIFO.
- The block issues each command as a compliant APB transfer. Issue is gated by pe_busy, so configuration never changes under an active computation.
- Returns one response per command, with read data and a timeout error flag. Sits between the host/config bus and the pe_cell APB slave port.

Parameters:
- WID_PADDR, 8, APB address width
- WID_PDATA, 32, APB data width
- DEPTH, 8, command FIFO entries (power of 2, >=2)
- TIMEOUT, 255, max ACCESS cycles waiting for pready before abort (>=1)

Ports:
- clk  in  1  clock, all logic on rising edge
- rst  in  1  synchronous reset, active-high
- cmd_valid  in  1  command push request
- cmd_ready  out  1  FIFO not full; push occurs when cmd_valid & cmd_ready
- cmd_write  in  1  1=write, 0=read
- cmd_addr  in  WID_PADDR  register address
- cmd_wdata  in  WID_PDATA  write data (ignored for reads)
- pe_busy  in  1  pe_cell computing; blocks new transfer start
- psel  out  1  APB select
- penable  out  1  APB enable
- pwrite  out  1  APB direction
- paddr  out  WID_PADDR  APB address
- pwdata  out  WID_PDATA  APB write data
- prdata  in  WID_PDATA  APB read data
- pready  in  1  APB ready
- rsp_valid  out  1  one-cycle response pulse, no backpressure
- rsp_write  out  1  echoes command type
- rsp_rdata  out  WID_PDATA  read data; 0 for writes and on timeout
- rsp_err  out  1  1 = transfer aborted by timeout
- fifo_count  out  $clog2(DEPTH)+1  current FIFO occupancy
- idle  out  1  FIFO empty and FSM in IDLE

Behaviour:
- Reset (rst=1 at clk edge): FIFO emptied, FSM->IDLE, timeout counter 0.
  - Outputs after reset: psel=0, penable=0, pwrite=0, paddr=0, pwdata=0, rsp_valid=0, rsp_write=0, rsp_rdata=0, rsp_err=0, fifo_count=0, cmd_ready=1, idle=1.
  - Reset mid-transfer drops the bus immediately (psel=0 the next cycle), with no response for the in-flight command.
- FIFO:
  - cmd_ready = (fifo_count < DEPTH), registered-equivalent, no combinational path from cmd_valid.
  - Push when full is impossible (ready low). Push and pop in the same cycle are both allowed; count unchanged.
  - Pointers wrap modulo DEPTH.
- FSM states: IDLE, SETUP, ACCESS, RESP.
- IDLE:
  - If FIFO non-empty and pe_busy=0: pop head into the command register, drive paddr/pwrite/pwdata, go to SETUP.
  - If pe_busy=1, stay in IDLE. The bus stays quiet (psel=0).
- SETUP: psel=1, penable=0 for exactly one cycle -> ACCESS.
- ACCESS:
  - psel=1, penable=1; timeout counter increments each cycle pready=0.
  - pready=1: capture prdata (reads only) -> RESP, err=0.
  - Counter reaches TIMEOUT with pready=0: abort -> RESP, err=1, rdata=0.
- RESP:
  - psel=0, penable=0; rsp_valid=1 for one cycle with registered rsp_write/rsp_rdata/rsp_err.
  - Then -> IDLE. Counter cleared.
- Bus stability: paddr/pwrite/pwdata are held constant from SETUP through the last ACCESS cycle. They keep their last values in IDLE/RESP.
- pe_busy is sampled only in IDLE. Rising during SETUP/ACCESS does not abort the transfer.
- Latency:
  - Zero-wait-state transfer, FIFO already holding the command: IDLE->SETUP->ACCESS->RESP, so rsp_valid 3 cycles after the pop edge.
  - Minimum command spacing on the bus: 4 cycles.
  - Push into an empty FIFO is visible to IDLE the next cycle.
- idle = (fifo_count==0) & (state==IDLE).
- Responses return strictly in command order, exactly one per popped command.

Test Plan:
- Write 0xA5A5_0001 to addr 0x04 with pready tied 1 -> psel high 2 cycles, penable high on the 2nd, pwdata=0xA5A5_0001, then rsp_valid with rsp_write=1, rsp_err=0, rsp_rdata=0.
- Read addr 0x08, slave inserts 3 wait states returning 0x0000_00FF -> ACCESS lasts 4 cycles with paddr stable; rsp_rdata=0x0000_00FF, rsp_err=0.
- Push 9 commands back-to-back with DEPTH=8 while pe_busy=1 -> cmd_ready=0 after the 8th, fifo_count=8, no psel. Drop pe_busy -> 8 transfers run in push order, count drains to 0, idle=1.
- Read with pready held 0, TIMEOUT=255 -> abort after 255 ACCESS cycles; rsp_err=1, rsp_rdata=0. The next queued command still executes normally.
- Assert pe_busy mid-ACCESS -> current transfer completes. The next command waits in IDLE until pe_busy=0.
- Assert rst during ACCESS with 3 commands queued -> next cycle psel=0, fifo_count=0, no rsp_valid; a new command after reset completes correctly.

Source files
------------

// File: rtl/pe_cell_apb_sequencer.sv
// Queued APB master: commands are buffered in a small FIFO and issued one at a
// time as APB transfers once pe_busy is low; one response is returned per command.
module pe_cell_apb_sequencer #(
    parameter int WID_PADDR = 8,
    parameter int WID_PDATA = 32,
    parameter int DEPTH     = 8,
    parameter int TIMEOUT   = 255
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       cmd_valid,
    output logic                       cmd_ready,
    input  logic                       cmd_write,
    input  logic [WID_PADDR-1:0]       cmd_addr,
    input  logic [WID_PDATA-1:0]       cmd_wdata,
    input  logic                       pe_busy,
    output logic                       psel,
    output logic                       penable,
    output logic                       pwrite,
    output logic [WID_PADDR-1:0]       paddr,
    output logic [WID_PDATA-1:0]       pwdata,
    input  logic [WID_PDATA-1:0]       prdata,
    input  logic                       pready,
    output logic                       rsp_valid,
    output logic                       rsp_write,
    output logic [WID_PDATA-1:0]       rsp_rdata,
    output logic                       rsp_err,
    output logic [$clog2(DEPTH):0]     fifo_count,
    output logic                       idle
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(TIMEOUT + 1);
    localparam int EW = 1 + WID_PADDR + WID_PDATA;

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

    state_t          state, state_nxt;
    logic [EW-1:0]   mem [DEPTH];
    logic [PW-1:0]   wr_ptr, rd_ptr;
    logic [PW:0]     count;
    logic [CW-1:0]   tcnt;
    logic            push, pop, done_ok, done_to;

    assign cmd_ready  = (count < (PW+1)'(DEPTH));
    assign push       = cmd_valid & cmd_ready;
    assign pop        = (state == IDLE) && (count != '0) && !pe_busy;
    assign done_ok    = (state == ACCESS) && pready;
    assign done_to    = (state == ACCESS) && !pready && (tcnt == CW'(TIMEOUT - 1));
    assign fifo_count = count;
    assign idle       = (count == '0) && (state == IDLE);

    // FIFO storage, written on push (no reset needed for the data array)
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= {cmd_write, cmd_addr, cmd_wdata};
    end

    // FIFO pointers and occupancy; pointers wrap naturally at DEPTH
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next-state logic and APB/response strobes decoded from state
    always_comb begin
        state_nxt = state;
        psel      = 1'b0;
        penable   = 1'b0;
        rsp_valid = 1'b0;
        case (state)
            IDLE:    if (pop) state_nxt = SETUP;
            SETUP: begin
                psel      = 1'b1;
                state_nxt = ACCESS;
            end
            ACCESS: begin
                psel    = 1'b1;
                penable = 1'b1;
                if (done_ok || done_to) state_nxt = RESP;
            end
            RESP: begin
                rsp_valid = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Bus address/data loaded at pop and held until the next pop
    always_ff @(posedge clk) begin
        if (rst) begin
            pwrite <= 1'b0;
            paddr  <= '0;
            pwdata <= '0;
        end else if (pop) begin
            {pwrite, paddr, pwdata} <= mem[rd_ptr];
        end
    end

    // Wait-state counter, live only in ACCESS
    always_ff @(posedge clk) begin
        if (rst || state != ACCESS) tcnt <= '0;
        else if (!pready)           tcnt <= tcnt + 1'b1;
    end

    // Response registers captured at the end of ACCESS
    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_write <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else if (done_ok) begin
            rsp_write <= pwrite;
            rsp_rdata <= pwrite ? '0 : prdata;
            rsp_err   <= 1'b0;
        end else if (done_to) begin
            rsp_write <= pwrite;
            rsp_rdata <= '0;
            rsp_err   <= 1'b1;
        end
    end
endmodule

// File: tb/tb_pe_cell_apb_sequencer.sv
// Randomized bench: commands are tracked in a queue, every APB transfer seen on
// the bus is matched against the queue head and responses are predicted from it.
module tb_pe_cell_apb_sequencer;
    localparam int WA = 8;
    localparam int WD = 32;
    localparam int DEPTH = 8;
    localparam int TIMEOUT = 255;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst, cmd_valid, cmd_ready, cmd_write, pe_busy;
    logic [WA-1:0] cmd_addr, paddr;
    logic [WD-1:0] cmd_wdata, pwdata, prdata, rsp_rdata;
    logic psel, penable, pwrite, pready, rsp_valid, rsp_write, rsp_err, idle;
    logic [$clog2(DEPTH):0] fifo_count;

    pe_cell_apb_sequencer #(.WID_PADDR(WA), .WID_PDATA(WD), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_write(cmd_write), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .pe_busy(pe_busy), .psel(psel), .penable(penable), .pwrite(pwrite),
        .paddr(paddr), .pwdata(pwdata), .prdata(prdata), .pready(pready),
        .rsp_valid(rsp_valid), .rsp_write(rsp_write), .rsp_rdata(rsp_rdata),
        .rsp_err(rsp_err), .fifo_count(fifo_count), .idle(idle)
    );

    typedef struct packed {logic w; logic [WA-1:0] a; logic [WD-1:0] d;} cmd_t;
    typedef struct packed {logic w; logic [WD-1:0] r; logic e;} rsp_t;

    cmd_t q[$];
    cmd_t cur;
    rsp_t exp_r;
    int checks = 0, errors = 0;
    bit rsp_due = 0, expect_setup = 0, just_reset = 0;
    bit hang = 0, rand_wait = 0, rd_fixed = 0;
    int nwait = 0, acc_wait = 0, err_seen = 0;
    logic [WD-1:0] rd_val = '0, last_rdata = '0;
    logic last_write = 0, last_err = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // One clock cycle: check outputs against the model, drive the slave, advance.
    task automatic tick();
        bit in_setup, in_access, nxt_due, nxt_setup;
        int qs;
        if (rst) begin
            @(posedge clk); #1;
            q.delete();
            rsp_due = 0; expect_setup = 0; acc_wait = 0; just_reset = 1;
            return;
        end
        if (just_reset) begin
            check("rst_psel", psel, 0);        check("rst_penable", penable, 0);
            check("rst_pwrite", pwrite, 0);    check("rst_paddr", paddr, 0);
            check("rst_pwdata", pwdata, 0);    check("rst_rsp_valid", rsp_valid, 0);
            check("rst_rsp_write", rsp_write, 0); check("rst_rsp_rdata", rsp_rdata, 0);
            check("rst_rsp_err", rsp_err, 0);  check("rst_count", fifo_count, 0);
            check("rst_ready", cmd_ready, 1);  check("rst_idle", idle, 1);
            just_reset = 0;
        end
        in_setup  = psel && !penable;
        in_access = psel && penable;
        check("setup_start", in_setup, expect_setup);
        check("rsp_valid", rsp_valid, rsp_due);
        if (rsp_due && rsp_valid) begin
            check("rsp_write", rsp_write, exp_r.w);
            check("rsp_rdata", rsp_rdata, exp_r.r);
            check("rsp_err", rsp_err, exp_r.e);
            check("resp_bus_quiet", psel, 0);
            last_rdata = rsp_rdata; last_write = rsp_write; last_err = rsp_err;
            if (rsp_err) err_seen++;
        end
        if (in_setup) begin
            if (q.size() > 0) cur = q.pop_front();
            check("setup_paddr", paddr, cur.a);
            check("setup_pwrite", pwrite, cur.w);
            check("setup_pwdata", pwdata, cur.d);
            acc_wait = 0;
            if (rand_wait) nwait = $urandom_range(0, 3);
        end
        if (in_access) begin
            check("acc_paddr", paddr, cur.a);
            check("acc_pwrite", pwrite, cur.w);
            check("acc_pwdata", pwdata, cur.d);
        end
        qs = q.size();
        check("fifo_count", fifo_count, qs);
        check("cmd_ready", cmd_ready, qs < DEPTH);
        check("idle", idle, qs == 0 && !psel && !rsp_due);
        prdata = rd_fixed ? rd_val : $urandom;
        pready = in_access ? (!hang && acc_wait >= nwait) : 1'($urandom);
        nxt_due = 0;
        if (in_access) begin
            if (pready) begin
                exp_r.w = cur.w; exp_r.r = cur.w ? '0 : prdata; exp_r.e = 1'b0;
                nxt_due = 1;
            end else begin
                acc_wait++;
                if (acc_wait == TIMEOUT) begin
                    exp_r.w = cur.w; exp_r.r = '0; exp_r.e = 1'b1;
                    nxt_due = 1;
                end
            end
        end
        nxt_setup = (qs > 0) && !pe_busy && !psel && !rsp_due;
        if (cmd_valid && cmd_ready) q.push_back({cmd_write, cmd_addr, cmd_wdata});
        @(posedge clk); #1;
        rsp_due = nxt_due;
        expect_setup = nxt_setup;
    endtask

    task automatic push_cmd(input logic w, input logic [WA-1:0] a, input logic [WD-1:0] d);
        bit acc = 0;
        cmd_valid = 1; cmd_write = w; cmd_addr = a; cmd_wdata = d;
        for (int i = 0; i < 2000 && !acc; i++) begin
            acc = cmd_ready;
            tick();
        end
        cmd_valid = 0;
        check("push_accepted", acc, 1);
    endtask

    task automatic drain(input int max);
        int n = 0;
        cmd_valid = 0;
        while (!(idle && !rsp_due) && n < max) begin
            tick();
            n++;
        end
        check("drain_idle", idle, 1);
    endtask

    task automatic wait_access(input int max);
        int n = 0;
        while (!(psel && penable) && n < max) begin
            tick();
            n++;
        end
        check("reached_access", psel && penable, 1);
    endtask

    initial begin
        int e0;
        rst = 1; cmd_valid = 0; cmd_write = 0; cmd_addr = '0; cmd_wdata = '0;
        pe_busy = 0; prdata = '0; pready = 0;
        @(posedge clk); #1;
        tick(); tick();
        rst = 0;

        // zero-wait write
        nwait = 0;
        push_cmd(1, 8'h04, 32'hA5A5_0001);
        drain(50);
        check("wr_rsp_write", last_write, 1);
        check("wr_rsp_err", last_err, 0);
        check("wr_rsp_rdata", last_rdata, 0);

        // read with three wait states
        nwait = 3; rd_fixed = 1; rd_val = 32'h0000_00FF;
        push_cmd(0, 8'h08, 32'h0);
        drain(50);
        check("rd_rsp_rdata", last_rdata, 32'hFF);
        check("rd_rsp_err", last_err, 0);
        rd_fixed = 0;

        // fill FIFO while busy, then release
        nwait = 0; pe_busy = 1;
        for (int i = 0; i < 9; i++) begin
            cmd_valid = 1; cmd_write = i[0]; cmd_addr = WA'(8'h10 + i); cmd_wdata = $urandom;
            tick();
        end
        cmd_valid = 0;
        check("full_count", fifo_count, DEPTH);
        check("full_ready", cmd_ready, 0);
        tick(); tick();
        check("busy_no_psel", psel, 0);
        pe_busy = 0;
        drain(200);

        // timeout, followed by a normal command
        hang = 1; e0 = err_seen;
        push_cmd(0, 8'h20, 32'h0);
        push_cmd(1, 8'h24, 32'h1234_5678);
        for (int n = 0; n < 400 && err_seen == e0; n++) tick();
        check("timeout_err", err_seen, e0 + 1);
        hang = 0;
        drain(50);
        check("after_timeout_ok", last_err, 0);

        // pe_busy raised mid-transfer
        nwait = 3;
        push_cmd(1, 8'h30, 32'hCAFE_0001);
        push_cmd(0, 8'h34, 32'h0);
        wait_access(20);
        pe_busy = 1;
        for (int i = 0; i < 12; i++) tick();
        check("busy_hold_count", fifo_count, 1);
        check("busy_hold_psel", psel, 0);
        pe_busy = 0;
        drain(50);

        // reset during ACCESS with three commands queued
        nwait = 10;
        for (int i = 0; i < 4; i++) push_cmd(1, WA'(8'h40 + i), $urandom);
        wait_access(20);
        check("pre_rst_count", fifo_count, 3);
        rst = 1; tick(); rst = 0;
        nwait = 0;
        push_cmd(1, 8'h50, 32'h0BAD_F00D);
        drain(50);
        check("post_rst_rsp", last_write, 1);

        // random traffic
        rand_wait = 1;
        for (int i = 0; i < 3000; i++) begin
            cmd_valid = 1'($urandom_range(0, 1));
            cmd_write = 1'($urandom);
            cmd_addr  = WA'($urandom);
            cmd_wdata = $urandom;
            pe_busy   = ($urandom_range(0, 3) == 0);
            tick();
        end
        pe_busy = 0;
        drain(300);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
